// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb
// Description : Two-port arbiter/sequencer for an external async SRAM.
//               Video reads have priority, bounded by a burst limit
//               while a CPU request is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb #(
    parameter int AW        = 21,
    parameter int DW        = 8,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2,
    parameter int VBURST    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          v_req,
    input  logic [AW-1:0] v_addr,
    output logic          v_ack,
    output logic [DW-1:0] v_data,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_ce,
    output logic          sram_oe,
    output logic          sram_we
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_END  = 2'd3
    } state_t;

    // Strobe counters count down to zero, so they are loaded with width-1.
    localparam logic [3:0] C_RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] C_WR_LOAD = 4'(WR_CYCLES - 1);
    localparam logic [3:0] C_VBURST  = 4'(VBURST);

    state_t        r_state, w_state;
    logic [3:0]    r_cnt,   w_cnt;
    logic [3:0]    r_vcnt,  w_vcnt;
    logic          r_gnt_v, w_gnt_v;

    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_dout;
    logic [DW-1:0] w_vdata;
    logic [DW-1:0] w_rdata;
    logic          w_vack;
    logic          w_cack;
    logic          w_ce;
    logic          w_oe;
    logic          w_we;
    logic          w_doe;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_vcnt  = r_vcnt;
        w_gnt_v = r_gnt_v;
        w_addr  = sram_addr;
        w_dout  = sram_dout;
        w_vdata = v_data;
        w_rdata = c_rdata;
        w_vack  = 1'b0;
        w_cack  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (v_req && (!c_req || (r_vcnt < C_VBURST))) begin
                    w_state = S_RD;
                    w_gnt_v = 1'b1;
                    w_addr  = v_addr;
                    w_cnt   = C_RD_LOAD;
                    // Only consecutive grants made while the CPU waits count.
                    w_vcnt  = c_req ? (r_vcnt + 4'd1) : 4'd0;
                end else if (c_req) begin
                    w_gnt_v = 1'b0;
                    w_addr  = c_addr;
                    w_vcnt  = 4'd0;
                    if (c_wr) begin
                        w_state = S_WR;
                        w_cnt   = C_WR_LOAD;
                        w_dout  = c_wdata;
                    end else begin
                        w_state = S_RD;
                        w_cnt   = C_RD_LOAD;
                    end
                end
            end
            S_RD: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_END;
                    w_vack  = r_gnt_v;
                    w_cack  = !r_gnt_v;
                    if (r_gnt_v) begin
                        w_vdata = sram_din;
                    end else begin
                        w_rdata = sram_din;
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_WR: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_END;
                    w_cack  = 1'b1;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_END: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Strobes follow the next state so they are registered alongside it.
        w_ce  = !((w_state == S_RD) || (w_state == S_WR));
        w_oe  = (w_state != S_RD);
        w_we  = (w_state != S_WR);
        w_doe = (w_state == S_WR) || ((w_state == S_END) && (r_state == S_WR));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_vcnt    <= 4'd0;
            r_gnt_v   <= 1'b0;
            sram_addr <= '0;
            sram_dout <= '0;
            v_data    <= '0;
            c_rdata   <= '0;
            v_ack     <= 1'b0;
            c_ack     <= 1'b0;
            sram_ce   <= 1'b1;
            sram_oe   <= 1'b1;
            sram_we   <= 1'b1;
            sram_doe  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_vcnt    <= w_vcnt;
            r_gnt_v   <= w_gnt_v;
            sram_addr <= w_addr;
            sram_dout <= w_dout;
            v_data    <= w_vdata;
            c_rdata   <= w_rdata;
            v_ack     <= w_vack;
            c_ack     <= w_cack;
            sram_ce   <= w_ce;
            sram_oe   <= w_oe;
            sram_we   <= w_we;
            sram_doe  <= w_doe;
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_arb.md
# sram_arb

Arbiter and sequencer for the board's external 8-bit asynchronous SRAM (21-bit address). It shares the SRAM between a high-priority video scanout read port and a lower-priority CPU read/write port. It generates the registered active-low ce/oe/we strobes, address, write data and data-bus output enable. It sits between the VGA engine and the CPU I/O decode (register at 16'h4000) in the top level, and replaces direct GPIO control of the SRAM strobes.

## Interface
- AW, 21, SRAM address width
- DW, 8, SRAM data width
- RD_CYCLES, 2, cycles oe/ce held low per read (1..15)
- WR_CYCLES, 2, cycles we/ce held low per write (1..15)
- VBURST, 4, max consecutive video grants while CPU request pending (1..15)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- v_req  in  1  video read request; held until v_ack
- v_addr  in  AW  video read address; stable while v_req
- v_ack  out  1  one-cycle pulse; v_data valid this cycle
- v_data  out  DW  video read data, held until next video ack
- c_req  in  1  CPU request; held until c_ack
- c_wr  in  1  1 = write, 0 = read; stable while c_req
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  one-cycle completion pulse
- c_rdata  out  DW  CPU read data, valid with c_ack, held after
- sram_addr  out  AW  registered SRAM address
- sram_dout  out  DW  registered write data
- sram_doe  out  1  1 = top level drives sram_data with sram_dout
- sram_din  in  DW  SRAM data bus input
- sram_ce, sram_oe, sram_we  out  1 each  active-low strobes

## Operation
- States: IDLE, RD, WR, END. All outputs are registered.
- IDLE arbitration applies only when some request is asserted:
  - If v_req is high and (c_req is low or vcnt < VBURST): grant video. vcnt increments if c_req is high, else vcnt clears.
  - Otherwise, if c_req is high: grant CPU and clear vcnt.
  - Grant latches the address (and c_wr/c_wdata), loads the strobe counter, and enters RD, or WR for a CPU write.
- RD: ce=0, oe=0, sram_doe=0 for RD_CYCLES cycles. sram_din is captured into the granted port's data register on the last RD cycle's closing edge. Then enter END.
- WR: ce=0, we=0, oe=1, sram_doe=1 for WR_CYCLES cycles. Then enter END.
- END: ce=oe=we=1. sram_doe stays 1 after a write for data hold and drops the cycle after. The granted port's ack is 1. Next state is IDLE.
- The requester drops req in the cycle after ack, so IDLE never sees a stale request.
- Address and data outputs hold their last values when idle.
- Video never writes; v_data is never altered by a CPU access.

## Timing
- Reset values: sram_ce=sram_oe=sram_we=1, sram_doe=0, sram_addr=0, sram_dout=0, v_ack=c_ack=0, v_data=c_rdata=0, state IDLE, vcnt=0.
- Reset assertion forces the strobes inactive in the same instant, independent of clk. An in-flight access is abandoned with no ack and no data-register update.
- Read: request seen in IDLE at cycle 0; strobes low cycles 1..RD_CYCLES; ack at cycle RD_CYCLES+1. Back-to-back period is RD_CYCLES+2.
- Write: strobes low cycles 1..WR_CYCLES; END (ack) at WR_CYCLES+1; sram_doe low from WR_CYCLES+2. Period is WR_CYCLES+2.
- Simultaneous v_req and c_req with vcnt < VBURST: video wins.
- CPU worst-case wait is VBURST video accesses plus one in-progress access.
- sram_addr never changes while ce=0. Data is driven onto the bus only while we is low and in END.
- v_ack and c_ack are never asserted in the same cycle.

## Test plan
- Reset during WR (cycle 1): strobes go to 1 immediately, sram_doe=0, no c_ack; after release, state is IDLE and a fresh read completes normally.
- Video read, defaults, v_addr=21'h1ABCD, model returns 8'h5A: ce/oe low exactly 2 cycles with sram_addr=21'h1ABCD; v_ack at cycle 3 with v_data=8'h5A.
- CPU write, c_addr=21'h00010, c_wdata=8'hC3: we low 2 cycles with sram_doe=1 and sram_dout=8'hC3; c_ack at cycle 3; sram_doe=0 at cycle 4; read-back returns 8'hC3 with c_ack.
- v_req held continuously and c_req raised together, VBURST=4: exactly 4 v_acks, then one c_ack, then video resumes; no cycle has both acks.
- Back-to-back video reads at addresses 0..7: one v_ack every 4 cycles; the data sequence matches the model memory.
- RD_CYCLES=1, WR_CYCLES=3: strobe widths are 1 and 3 cycles; acks at cycles 2 and 4 respectively.
